// File: rtl/io_seg_pwr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : io_seg_pwr_seq                                                |
// | Description : Power-up / power-down sequencer for IO ring segments. Each    |
// |               segment's supply-good is synchronised and debounced. The pad  |
// |               isolation is then released and the pad drivers enabled. One   |
// |               segment is sequenced at a time in round-robin order, with a   |
// |               stagger gap between grants to limit inrush. Request drops     |
// |               and supply loss are handled per segment, concurrently with    |
// |               the sequencer.                                                |
// | Ports       : clk, rst           - clock, synchronous active-high reset     |
// |               seg_req_i          - per-segment power/enable request (level) |
// |               pwr_ok_async_i     - per-segment supply-good, async to clk    |
// |               fault_clr_i        - pulse, clears all sticky fault bits      |
// |               seg_iso_o          - pad isolation (1 = isolated)             |
// |               seg_en_o           - pad driver enable                        |
// |               fault_o            - sticky supply-lost-while-active flag     |
// |               busy_o             - sequencer not idle                       |
// |               grant_idx_o        - segment being sequenced (valid w/ busy)  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module io_seg_pwr_seq #(
   parameter int N_SEG       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CNT     = 100,
   parameter int STAGGER     = 16,
   parameter int CNT_W       = 8,
   localparam int IDX_W      = (N_SEG > 1) ? $clog2(N_SEG) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SEG-1:0] seg_req_i,
   input  logic [N_SEG-1:0] pwr_ok_async_i,
   input  logic             fault_clr_i,
   output logic [N_SEG-1:0] seg_iso_o,
   output logic [N_SEG-1:0] seg_en_o,
   output logic [N_SEG-1:0] fault_o,
   output logic             busy_o,
   output logic [IDX_W-1:0] grant_idx_o
);

   localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEB_CNT - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(STAGGER - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_RELEASE  = 3'd2,
      ST_ENABLE   = 3'd3,
      ST_GAP      = 3'd4
   } state_t;

   // Synchroniser chain; stage SYNC_STAGES-1 is the clean pwr_ok.
   logic [SYNC_STAGES-1:0][N_SEG-1:0] sync_q;
   logic [N_SEG-1:0]                  pwr_ok_s;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] grant_q;
   logic [IDX_W-1:0] rr_q;
   logic             busy_q;
   logic [N_SEG-1:0] iso_q;
   logic [N_SEG-1:0] en_q;
   logic [N_SEG-1:0] fault_q;
   logic [N_SEG-1:0] active_q;
   // Second cycle of a normal power-down: drivers already off, isolation next.
   logic [N_SEG-1:0] pd_q;

   logic [N_SEG-1:0] elig;
   logic             pick_found_d;
   logic [IDX_W-1:0] pick_idx_d;
   logic [IDX_W-1:0] cand;
   logic             abort_g;

   assign pwr_ok_s = sync_q[SYNC_STAGES-1];
   assign elig     = seg_req_i & pwr_ok_s & ~active_q & ~fault_q;
   // Granted segment lost its supply or its request.
   assign abort_g  = !pwr_ok_s[grant_q] || !seg_req_i[grant_q];

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
      return (int'(g) == N_SEG - 1) ? '0 : g + 1'b1;
   endfunction

   // Round-robin pick: first eligible segment at or after rr_q, wrapping.
   always_comb begin
      pick_found_d = 1'b0;
      pick_idx_d   = '0;
      cand         = '0;
      for (int j = 0; j < N_SEG; j++) begin
         cand = IDX_W'((int'(rr_q) + j) % N_SEG);
         if (!pick_found_d && elig[cand]) begin
            pick_found_d = 1'b1;
            pick_idx_d   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= pwr_ok_async_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // Sequencer FSM together with the per-segment power-down / supply-loss
   // handling. The FSM only touches the granted segment while it is not yet
   // active, and the per-segment logic only touches active segments, so the
   // two never write the same bit in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         grant_q  <= '0;
         rr_q     <= '0;
         busy_q   <= 1'b0;
         iso_q    <= '1;
         en_q     <= '0;
         fault_q  <= '0;
         active_q <= '0;
         pd_q     <= '0;
      end else begin
         for (int i = 0; i < N_SEG; i++) begin
            // A fault set below overrides the clear for the same bit.
            fault_q[i] <= fault_q[i] & ~fault_clr_i;
            if (active_q[i] && !pwr_ok_s[i]) begin
               en_q[i]     <= 1'b0;
               iso_q[i]    <= 1'b1;
               active_q[i] <= 1'b0;
               fault_q[i]  <= 1'b1;
               pd_q[i]     <= 1'b0;
            end else if (pd_q[i]) begin
               // Completes even if the request has returned meanwhile.
               iso_q[i]    <= 1'b1;
               active_q[i] <= 1'b0;
               pd_q[i]     <= 1'b0;
            end else if (active_q[i] && !seg_req_i[i]) begin
               en_q[i]     <= 1'b0;
               pd_q[i]     <= 1'b1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (pick_found_d) begin
                  grant_q <= pick_idx_d;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_DEBOUNCE;
               end
            end
            ST_DEBOUNCE: begin
               if (abort_g) begin
                  rr_q    <= next_idx(grant_q);
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (cnt_q == C_DEB_LAST) begin
                  state_q <= ST_RELEASE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (abort_g) begin
                  iso_q[grant_q] <= 1'b1;
                  rr_q           <= next_idx(grant_q);
                  busy_q         <= 1'b0;
                  state_q        <= ST_IDLE;
               end else begin
                  iso_q[grant_q] <= 1'b0;
                  state_q        <= ST_ENABLE;
               end
            end
            ST_ENABLE: begin
               en_q[grant_q]     <= 1'b1;
               active_q[grant_q] <= 1'b1;
               cnt_q             <= '0;
               state_q           <= ST_GAP;
            end
            ST_GAP: begin
               if (cnt_q == C_GAP_LAST) begin
                  rr_q    <= next_idx(grant_q);
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign seg_iso_o   = iso_q;
   assign seg_en_o    = en_q;
   assign fault_o     = fault_q;
   assign busy_o      = busy_q;
   assign grant_idx_o = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_io_seg_pwr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_io_seg_pwr_seq                                             |
// | Description : Directed self-checking bench for io_seg_pwr_seq with          |
// |               DEB_CNT=4, STAGGER=3, SYNC_STAGES=2, N_SEG=4.                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_io_seg_pwr_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] seg_req;
   logic [3:0] pwr_ok_async;
   logic       fault_clr;
   logic [3:0] seg_iso;
   logic [3:0] seg_en;
   logic [3:0] fault;
   logic       busy;
   logic [1:0] grant_idx;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int inv_viol   = 0;
   int base;
   int rise [4];

   io_seg_pwr_seq #(
      .N_SEG       (4),
      .SYNC_STAGES (2),
      .DEB_CNT     (4),
      .STAGGER     (3),
      .CNT_W       (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .seg_req_i      (seg_req),
      .pwr_ok_async_i (pwr_ok_async),
      .fault_clr_i    (fault_clr),
      .seg_iso_o      (seg_iso),
      .seg_en_o       (seg_en),
      .fault_o        (fault),
      .busy_o         (busy),
      .grant_idx_o    (grant_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required $finish before 200000");
      $fatal(1, "watchdog expired");
   end

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if ((seg_en & seg_iso) != 4'b0000) inv_viol++;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pads(input string tag, input logic [3:0] iso_e,
                           input logic [3:0] en_e, input logic [3:0] flt_e);
      chk({tag, ".iso"},   32'(seg_iso), 32'(iso_e));
      chk({tag, ".en"},    32'(seg_en),  32'(en_e));
      chk({tag, ".fault"}, 32'(fault),   32'(flt_e));
   endtask

   initial begin
      rst          = 1'b1;
      seg_req      = 4'b0000;
      pwr_ok_async = 4'b0010;
      fault_clr    = 1'b0;

      // ---------------- reset then single request on segment 1
      ticks(3);
      chk_pads("reset", 4'b1111, 4'b0000, 4'b0000);
      chk("reset.busy",  32'(busy),      32'd0);
      chk("reset.grant", 32'(grant_idx), 32'd0);
      rst     = 1'b0;
      seg_req = 4'b0010;
      ticks(2);
      chk("single.sync_wait_busy", 32'(busy), 32'd0);
      tick();                                   // grant edge k
      chk("single.busy",  32'(busy),      32'd1);
      chk("single.grant", 32'(grant_idx), 32'd1);
      ticks(4);                                 // k+4
      chk_pads("single.k4", 4'b1111, 4'b0000, 4'b0000);
      tick();                                   // k+5
      chk_pads("single.k5", 4'b1101, 4'b0000, 4'b0000);
      tick();                                   // k+6
      chk_pads("single.k6", 4'b1101, 4'b0010, 4'b0000);
      chk("single.k6.busy", 32'(busy), 32'd1);
      ticks(2);                                 // k+8
      chk("single.k8.busy", 32'(busy), 32'd1);
      tick();                                   // k+9
      chk("single.k9.busy", 32'(busy), 32'd0);

      // ---------------- round robin with stagger
      rst          = 1'b1;
      seg_req      = 4'b0000;
      pwr_ok_async = 4'b1111;
      ticks(2);
      rst     = 1'b0;
      seg_req = 4'b1111;
      ticks(3);
      base = cyc;
      chk("rr.grant0", 32'(grant_idx), 32'd0);
      for (int s = 0; s < 4; s++) rise[s] = -1;
      for (int c = 0; c < 40; c++) begin
         tick();
         for (int s = 0; s < 4; s++)
            if (seg_en[s] && rise[s] < 0) rise[s] = cyc - base;
      end
      chk("rr.rise0", 32'(rise[0]), 32'd6);
      chk("rr.rise1", 32'(rise[1]), 32'd16);
      chk("rr.rise2", 32'(rise[2]), 32'd26);
      chk("rr.rise3", 32'(rise[3]), 32'd36);
      chk_pads("rr.end", 4'b0000, 4'b1111, 4'b0000);
      chk("rr.end.busy", 32'(busy), 32'd0);

      // ---------------- normal power-down of segment 0
      seg_req = 4'b1110;
      tick();
      chk_pads("pd.e1", 4'b0000, 4'b1110, 4'b0000);
      tick();
      chk_pads("pd.e2", 4'b0001, 4'b1110, 4'b0000);

      // ---------------- supply loss on segment 3
      pwr_ok_async = 4'b0111;
      ticks(2);
      chk_pads("loss.e2", 4'b0001, 4'b1110, 4'b0000);
      tick();
      chk_pads("loss.e3", 4'b1001, 4'b0110, 4'b1000);
      pwr_ok_async = 4'b1111;
      ticks(8);
      chk("loss.no_regrant.busy", 32'(busy), 32'd0);
      chk_pads("loss.held", 4'b1001, 4'b0110, 4'b1000);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("loss.clr.fault", 32'(fault), 32'd0);
      chk("loss.clr.busy",  32'(busy),  32'd0);
      tick();                                   // re-grant edge k
      chk("loss.regrant.busy",  32'(busy),      32'd1);
      chk("loss.regrant.grant", 32'(grant_idx), 32'd3);
      ticks(5);
      chk_pads("loss.k5", 4'b0001, 4'b0110, 4'b0000);
      tick();
      chk_pads("loss.k6", 4'b0001, 4'b1110, 4'b0000);
      ticks(3);
      chk("loss.k9.busy", 32'(busy), 32'd0);

      // ---------------- debounce abort on segment 2
      rst          = 1'b1;
      seg_req      = 4'b0000;
      ticks(2);
      rst     = 1'b0;
      seg_req = 4'b0100;
      ticks(3);                                 // grant edge k
      chk("abort.grant", 32'(grant_idx), 32'd2);
      seg_req      = 4'b0111;
      pwr_ok_async = 4'b1011;
      tick();                                   // k+1
      pwr_ok_async = 4'b1111;
      tick();                                   // k+2
      chk("abort.k2.busy", 32'(busy), 32'd1);
      tick();                                   // k+3: abort seen
      chk("abort.k3.busy", 32'(busy), 32'd0);
      chk_pads("abort.k3", 4'b1111, 4'b0000, 4'b0000);
      tick();                                   // k+4: rr pointer now 3
      chk("abort.k4.grant", 32'(grant_idx), 32'd0);
      chk("abort.k4.busy",  32'(busy),      32'd1);
      ticks(10);                                // k+14
      chk("abort.k14.grant", 32'(grant_idx), 32'd1);
      chk_pads("abort.k14", 4'b1110, 4'b0001, 4'b0000);
      ticks(10);                                // k+24 = G
      chk("abort.k24.grant", 32'(grant_idx), 32'd2);
      chk_pads("abort.k24", 4'b1100, 4'b0011, 4'b0000);

      // ---------------- fault_clr colliding with a new fault on segment 0
      pwr_ok_async = 4'b1110;
      ticks(2);                                 // G+2
      chk_pads("sim.g2", 4'b1100, 4'b0011, 4'b0000);
      fault_clr = 1'b1;
      tick();                                   // G+3
      fault_clr = 1'b0;
      chk_pads("sim.g3", 4'b1101, 4'b0010, 4'b0001);
      ticks(2);                                 // G+5: iso[2] released
      chk_pads("sim.g5", 4'b1001, 4'b0010, 4'b0001);
      chk("sim.g5.busy", 32'(busy), 32'd1);

      // ---------------- reset while in ENABLE
      rst = 1'b1;
      tick();
      chk_pads("rst_enable", 4'b1111, 4'b0000, 4'b0000);
      chk("rst_enable.busy",  32'(busy),      32'd0);
      chk("rst_enable.grant", 32'(grant_idx), 32'd0);
      rst = 1'b0;

      chk("iso_en_order", 32'(inv_viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/io_seg_pwr_seq.md
Name: io_seg_pwr_seq

Overview:
- Power-up/power-down sequencer for IO ring segments. Segments are separated by IO power-cut cells and each has its own IO supply.
- Per segment, the block synchronises and debounces the supply power-good, releases pad isolation, then enables the pad drivers.
- Power-ups are granted one segment at a time, round-robin, with a stagger gap between them to limit inrush.
- It sits in the always-on domain between the pad-ring supply detectors and the pad control inputs (isolation/enable).

Parameters:
- N_SEG, 4, number of IO segments controlled.
- SYNC_STAGES, 2, flops in each pwr_ok synchroniser (min 2).
- DEB_CNT, 100, cycles pwr_ok must stay high in DEBOUNCE before isolation is released (min 1).
- STAGGER, 16, idle cycles after a segment enable before the next grant (min 1).
- CNT_W, 8, shared counter width; must hold max(DEB_CNT, STAGGER).

Ports:
- clk  in  1  block clock.
- rst  in  1  synchronous reset, active-high.
- seg_req  in  N_SEG  level request per segment; 1 = segment should be powered/enabled.
- pwr_ok_async  in  N_SEG  supply-good from the segment detectors; asynchronous to clk.
- fault_clr  in  1  single-cycle pulse; clears all fault bits.
- seg_iso  out  N_SEG  pad isolation; 1 = isolated.
- seg_en  out  N_SEG  pad driver enable.
- fault  out  N_SEG  sticky flag: supply lost while the segment was active.
- busy  out  1  1 whenever the FSM is not in IDLE.
- grant_idx  out  $clog2(N_SEG)  segment currently being sequenced; valid while busy.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset values: seg_iso = all 1, seg_en = 0, fault = 0, busy = 0, grant_idx = 0, rr pointer = 0, FSM = IDLE, counter = 0, per-segment active = 0, synchronisers = 0.
  - Reset asserted mid-sequence forces these values at the next edge. There is no graceful power-down on reset.
- Synchronisation: pwr_ok_async passes through SYNC_STAGES flops to give pwr_ok_s. All logic below uses pwr_ok_s only.
- Eligibility: segment i is eligible when seg_req[i] & pwr_ok_s[i] & !active[i] & !fault[i].
- FSM states:
  - IDLE: choose the first eligible segment starting at the rr pointer, wrapping N_SEG-1 → 0. If one is found, latch it into grant_idx, clear the counter, and go to DEBOUNCE.
  - DEBOUNCE: if pwr_ok_s[g] = 0 or seg_req[g] = 0, abort to IDLE with rr pointer = g+1 mod N_SEG. Otherwise increment the counter. When counter = DEB_CNT-1, go to RELEASE.
  - RELEASE: seg_iso[g] ← 0; go to ENABLE.
  - ENABLE: seg_en[g] ← 1, active[g] ← 1, clear the counter; go to GAP.
  - GAP: count STAGGER cycles, then go to IDLE with rr pointer = g+1 mod N_SEG.
- Latency: if the grant edge is k, seg_iso[g] falls at edge k+DEB_CNT+1 and seg_en[g] rises at edge k+DEB_CNT+2. The next grant is possible no earlier than edge k+DEB_CNT+STAGGER+3.
- Ordering invariant: seg_en[i] = 1 implies seg_iso[i] = 0 in every cycle.
- Aborts from RELEASE: if pwr_ok_s[g] or seg_req[g] drops while in RELEASE, go to IDLE and restore seg_iso[g] ← 1 at the next edge. seg_en is not asserted.
- Normal power-down (per segment, concurrent with the FSM), when active[i] & !seg_req[i] & pwr_ok_s[i]:
  - seg_en[i] ← 0 at the next edge.
  - One edge later: seg_iso[i] ← 1 and active[i] ← 0.
  - If seg_req[i] returns during this two-cycle window, the power-down still completes; the segment later re-arbitrates normally.
- Supply loss (per segment, concurrent), when active[i] & !pwr_ok_s[i]:
  - At the next edge, seg_en[i] ← 0, seg_iso[i] ← 1, active[i] ← 0, and fault[i] ← 1, all together.
  - Supply loss takes precedence over a simultaneous request drop or an in-progress normal power-down.
- Fault:
  - fault[i] blocks eligibility until it is cleared.
  - fault_clr clears all fault bits at the next edge.
  - If a new fault set and fault_clr occur in the same cycle, the set wins for that bit.
- GAP: per-segment events for the just-enabled segment, such as supply loss, are still handled during GAP. GAP always runs to completion.
- busy = (FSM != IDLE), registered.

Test Plan:
- Reset then single request: DEB_CNT=4, STAGGER=3, pwr_ok_async[1] high, pulse rst, then seg_req=4'b0010 → grant_idx=1; seg_iso[1] falls 5 cycles after the grant; seg_en[1] rises 1 cycle later; busy stays high 3 more cycles; seg_iso/seg_en/fault of segments 0, 2, 3 unchanged at 1/0/0.
- Round-robin with stagger: all pwr_ok high, seg_req=4'b1111 → segments enabled in order 0, 1, 2, 3. Each pair of successive seg_en rises is exactly DEB_CNT+STAGGER+3 cycles apart, and no two segments are ever in DEBOUNCE together.
- Debounce abort: drop pwr_ok_async[2] for 1 cycle mid-DEBOUNCE → return to IDLE; seg_iso[2] stays 1 and seg_en[2] stays 0; segment 2 is re-granted only after other eligible segments, per the rr pointer.
- Normal power-down: enabled segment 0, deassert seg_req[0] → seg_en[0] is 0 after 1 edge, seg_iso[0] is 1 after 2 edges, and fault[0] stays 0.
- Supply loss and fault: enabled segment 3, drop pwr_ok_async[3] → after the SYNC_STAGES synchroniser latency plus one edge, seg_en[3]=0, seg_iso[3]=1 and fault[3]=1 in the same edge. With seg_req[3] held high, no re-grant occurs; after fault_clr, segment 3 is re-sequenced.
- Simultaneous events: fault_clr in the same cycle as a new supply-loss fault → that fault bit stays 1. Reset asserted during ENABLE → all outputs return to their reset values at the next edge.
